// File: rtl/mem_arb_pkg.sv
// Shared types and defaults for the unified memory-port arbiter.
// Holds the FSM/owner enums, the memory command bundle and parameter defaults.
package mem_arb_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      WAIT = 2'd2
   } state_t;

   typedef enum logic {
      OWN_I = 1'b0,
      OWN_D = 1'b1
   } owner_t;

   typedef struct packed {
      logic        we;
      logic [3:0]  be;
      logic [31:0] addr;
      logic [31:0] wdata;
   } mem_cmd_t;

   localparam int STREAK_MAX_DEF     = 4;
   localparam int TIMEOUT_CYCLES_DEF = 64;

endpackage

// File: rtl/arb_pick.sv
// Fetch/data priority pick with a D-grant streak limit; combinational pick, registered streak.
// Zero-cycle pick; a saturated streak hands the next slot to a waiting fetch.
module arb_pick #(
   parameter int STREAK_MAX = 4
) (
   input  logic clk,
   input  logic rst_n,
   input  logic if_req,
   input  logic d_req,
   input  logic i_gnt,
   input  logic d_gnt,
   output logic pick_d
);

   localparam int SW = $clog2(STREAK_MAX + 1);
   localparam logic [SW-1:0] STREAK_LIM = SW'(STREAK_MAX);

   logic [SW-1:0] streak;

   // A lone D request still wins when fetch is not waiting, even at the limit.
   assign pick_d = d_req && ((streak != STREAK_LIM) || !if_req);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         streak <= '0;
      end else if (!if_req || i_gnt) begin
         streak <= '0;
      end else if (d_gnt && (streak != STREAK_LIM)) begin
         streak <= streak + 1'b1;
      end
   end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between fetch (I) and data (D), one transaction in flight.
// Grant in the request cycle at best; response passes through combinationally; mem_gnt low stalls in REQ.
module mem_port_arbiter
   import mem_arb_pkg::*;
#(
   parameter int STREAK_MAX     = STREAK_MAX_DEF,
   parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        if_req,
   input  logic [31:0] if_addr,
   output logic        if_gnt,
   output logic        if_rvalid,
   output logic [31:0] if_rdata,
   output logic        if_err,
   input  logic        d_req,
   input  logic        d_we,
   input  logic [3:0]  d_be,
   input  logic [31:0] d_addr,
   input  logic [31:0] d_wdata,
   output logic        d_gnt,
   output logic        d_rvalid,
   output logic [31:0] d_rdata,
   output logic        d_err,
   output logic        mem_req,
   output logic        mem_we,
   output logic [3:0]  mem_be,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   input  logic        mem_gnt,
   input  logic        mem_rvalid,
   input  logic [31:0] mem_rdata,
   output logic        bus_err
);

   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

   state_t        state;
   owner_t        owner_q;
   owner_t        sel;
   owner_t        cur;
   logic          we_q;
   logic [TW-1:0] tmo_cnt;
   logic          bus_err_q;
   logic          pick_d;
   logic          any_req;
   logic          gnt;
   logic          in_wait;
   logic          tmo_hit;
   logic          rsp_vld;
   mem_cmd_t      i_cmd;
   mem_cmd_t      d_cmd;
   mem_cmd_t      cmd;

   arb_pick #(
      .STREAK_MAX(STREAK_MAX)
   ) u_pick (
      .clk    (clk),
      .rst_n  (rst_n),
      .if_req (if_req),
      .d_req  (d_req),
      .i_gnt  (if_gnt),
      .d_gnt  (d_gnt),
      .pick_d (pick_d)
   );

   assign any_req = if_req || d_req;
   assign sel     = pick_d ? OWN_D : OWN_I;
   assign cur     = (state == IDLE) ? sel : owner_q;
   assign mem_req = (state == REQ) || ((state == IDLE) && any_req);

   assign i_cmd = '{we: 1'b0, be: 4'hF, addr: if_addr, wdata: 32'h0};
   assign d_cmd = '{we: d_we, be: d_be, addr: d_addr, wdata: d_wdata};
   assign cmd   = mem_req ? ((cur == OWN_D) ? d_cmd : i_cmd) : '0;

   assign mem_we    = cmd.we;
   assign mem_be    = cmd.be;
   assign mem_addr  = cmd.addr;
   assign mem_wdata = cmd.wdata;

   assign gnt    = mem_req && mem_gnt;
   assign d_gnt  = gnt && (cur == OWN_D);
   assign if_gnt = gnt && (cur == OWN_I);

   // A real response in the last allowed cycle beats the timeout.
   assign in_wait = (state == WAIT);
   assign tmo_hit = in_wait && !mem_rvalid && (tmo_cnt == TMO_LAST);
   assign rsp_vld = in_wait && (mem_rvalid || tmo_hit);

   assign d_rvalid  = rsp_vld && (owner_q == OWN_D);
   assign d_err     = d_rvalid && tmo_hit;
   assign d_rdata   = (d_rvalid && mem_rvalid && !we_q) ? mem_rdata : 32'h0;
   assign if_rvalid = rsp_vld && (owner_q == OWN_I);
   assign if_err    = if_rvalid && tmo_hit;
   assign if_rdata  = (if_rvalid && mem_rvalid) ? mem_rdata : 32'h0;
   assign bus_err   = bus_err_q;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= IDLE;
         owner_q   <= OWN_D;
         we_q      <= 1'b0;
         tmo_cnt   <= '0;
         bus_err_q <= 1'b0;
      end else begin
         if (gnt) begin
            tmo_cnt <= '0;
         end else if (in_wait) begin
            tmo_cnt <= tmo_cnt + 1'b1;
         end
         if (tmo_hit) begin
            bus_err_q <= 1'b1;
         end
         case (state)
            IDLE: begin
               if (any_req) begin
                  owner_q <= sel;
                  we_q    <= (sel == OWN_D) && d_we;
                  state   <= mem_gnt ? WAIT : REQ;
               end
            end
            REQ: begin
               if (mem_gnt) begin
                  state <= WAIT;
               end
            end
            WAIT: begin
               if (rsp_vld) begin
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: a per-cycle vector table plus multi-cycle sequences.
module tb_mem_port_arbiter;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        if_req;
   logic [31:0] if_addr;
   logic        if_gnt;
   logic        if_rvalid;
   logic [31:0] if_rdata;
   logic        if_err;
   logic        d_req;
   logic        d_we;
   logic [3:0]  d_be;
   logic [31:0] d_addr;
   logic [31:0] d_wdata;
   logic        d_gnt;
   logic        d_rvalid;
   logic [31:0] d_rdata;
   logic        d_err;
   logic        mem_req;
   logic        mem_we;
   logic [3:0]  mem_be;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic        mem_gnt;
   logic        mem_rvalid;
   logic [31:0] mem_rdata;
   logic        bus_err;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   mem_port_arbiter #(
      .STREAK_MAX     (4),
      .TIMEOUT_CYCLES (8)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .if_req     (if_req),
      .if_addr    (if_addr),
      .if_gnt     (if_gnt),
      .if_rvalid  (if_rvalid),
      .if_rdata   (if_rdata),
      .if_err     (if_err),
      .d_req      (d_req),
      .d_we       (d_we),
      .d_be       (d_be),
      .d_addr     (d_addr),
      .d_wdata    (d_wdata),
      .d_gnt      (d_gnt),
      .d_rvalid   (d_rvalid),
      .d_rdata    (d_rdata),
      .d_err      (d_err),
      .mem_req    (mem_req),
      .mem_we     (mem_we),
      .mem_be     (mem_be),
      .mem_addr   (mem_addr),
      .mem_wdata  (mem_wdata),
      .mem_gnt    (mem_gnt),
      .mem_rvalid (mem_rvalid),
      .mem_rdata  (mem_rdata),
      .bus_err    (bus_err)
   );

   typedef struct packed {
      logic        rst_n;
      logic        if_req;
      logic [31:0] if_addr;
      logic        d_req;
      logic        d_we;
      logic [3:0]  d_be;
      logic [31:0] d_addr;
      logic [31:0] d_wdata;
      logic        mem_gnt;
      logic        mem_rvalid;
      logic [31:0] mem_rdata;
   } in_t;

   typedef struct packed {
      logic        mem_req;
      logic        mem_we;
      logic [3:0]  mem_be;
      logic [31:0] mem_addr;
      logic [31:0] mem_wdata;
      logic        if_gnt;
      logic        if_rvalid;
      logic [31:0] if_rdata;
      logic        if_err;
      logic        d_gnt;
      logic        d_rvalid;
      logic [31:0] d_rdata;
      logic        d_err;
      logic        bus_err;
   } out_t;

   typedef struct {
      string name;
      in_t   stim;
      out_t  exp;
   } vec_t;

   vec_t tbl[10];

   function automatic in_t mi(logic rs, logic ir, logic [31:0] ia, logic dr, logic dw,
                              logic [3:0] db, logic [31:0] da, logic [31:0] dwd,
                              logic mg, logic mv, logic [31:0] md);
      return '{rs, ir, ia, dr, dw, db, da, dwd, mg, mv, md};
   endfunction

   function automatic out_t mo(logic rq, logic we, logic [3:0] be, logic [31:0] ad,
                               logic [31:0] wd, logic ig, logic iv, logic [31:0] ird,
                               logic ie, logic dg, logic dv, logic [31:0] drd,
                               logic de, logic be_);
      return '{rq, we, be, ad, wd, ig, iv, ird, ie, dg, dv, drd, de, be_};
   endfunction

   function automatic out_t sample();
      return '{mem_req, mem_we, mem_be, mem_addr, mem_wdata, if_gnt, if_rvalid, if_rdata,
               if_err, d_gnt, d_rvalid, d_rdata, d_err, bus_err};
   endfunction

   task automatic apply(input in_t v);
      rst_n      = v.rst_n;
      if_req     = v.if_req;
      if_addr    = v.if_addr;
      d_req      = v.d_req;
      d_we       = v.d_we;
      d_be       = v.d_be;
      d_addr     = v.d_addr;
      d_wdata    = v.d_wdata;
      mem_gnt    = v.mem_gnt;
      mem_rvalid = v.mem_rvalid;
      mem_rdata  = v.mem_rdata;
   endtask

   task automatic check_all(input string name, input out_t exp);
      out_t got;
      got = sample();
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got=%h expected=%h", name, got, exp);
      end
   endtask

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got=%h expected=%h", name, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      bit exp_d;

      apply(mi(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      tick();
      tick();
      #1;
      check_all("reset_state", '0);
      tick();

      tbl[0] = '{"post_reset_rvalid_drop", mi(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 32'hAAAA_AAAA),
                 mo(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0)};
      tbl[1] = '{"fetch_gnt", mi(1, 1, 32'h100, 0, 0, 0, 0, 0, 1, 0, 0),
                 mo(1, 0, 4'hF, 32'h100, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0)};
      tbl[2] = '{"fetch_rsp", mi(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h13),
                 mo(0, 0, 0, 0, 0, 0, 1, 32'h13, 0, 0, 0, 0, 0, 0)};
      tbl[3] = '{"store_gnt", mi(1, 0, 0, 1, 1, 4'h3, 32'h200, 32'hDEAD_BEEF, 1, 0, 0),
                 mo(1, 1, 4'h3, 32'h200, 32'hDEAD_BEEF, 0, 0, 0, 0, 1, 0, 0, 0, 0)};
      tbl[4] = '{"store_wait", mi(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0),
                 mo(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0)};
      tbl[5] = '{"store_ack", mi(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h55),
                 mo(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0)};
      tbl[6] = '{"both_d_wins", mi(1, 1, 32'h104, 1, 0, 4'hF, 32'h300, 0, 1, 0, 0),
                 mo(1, 0, 4'hF, 32'h300, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0)};
      tbl[7] = '{"load_rsp_no_regrant", mi(1, 1, 32'h104, 0, 0, 0, 0, 0, 1, 1, 32'hCAFE_0001),
                 mo(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 32'hCAFE_0001, 0, 0)};
      tbl[8] = '{"fetch_after_load", mi(1, 1, 32'h104, 0, 0, 0, 0, 0, 1, 0, 0),
                 mo(1, 0, 4'hF, 32'h104, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0)};
      tbl[9] = '{"fetch_rsp2", mi(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h0040_0093),
                 mo(0, 0, 0, 0, 0, 0, 1, 32'h0040_0093, 0, 0, 0, 0, 0, 0)};

      for (int k = 0; k < 10; k++) begin
         apply(tbl[k].stim);
         #1;
         check_all(tbl[k].name, tbl[k].exp);
         tick();
      end

      // Both requesting back to back: streak limit yields D,D,D,D,I repeating.
      apply(mi(1, 1, 32'h1000, 1, 0, 4'hF, 32'h2000, 0, 1, 0, 0));
      for (int n = 0; n < 10; n++) begin
         exp_d      = (n % 5) != 4;
         mem_rvalid = 1'b0;
         #1;
         chk($sformatf("order_gnt_%0d", n), {30'h0, d_gnt, if_gnt}, {30'h0, exp_d, !exp_d});
         tick();
         mem_rvalid = 1'b1;
         mem_rdata  = 32'h100 + n;
         #1;
         chk($sformatf("order_rsp_%0d", n), {30'h0, d_rvalid, if_rvalid}, {30'h0, exp_d, !exp_d});
         tick();
      end

      // Memory stalls the grant for 5 cycles; command must hold steady.
      apply(mi(1, 0, 0, 1, 0, 4'hF, 32'h400, 0, 0, 0, 0));
      for (int c = 0; c < 5; c++) begin
         #1;
         chk($sformatf("stall_%0d", c), {mem_req, d_gnt, mem_addr[29:0]}, {1'b1, 1'b0, 30'h400});
         tick();
      end
      mem_gnt = 1'b1;
      #1;
      chk("stall_release", {mem_req, d_gnt, mem_addr[29:0]}, {1'b1, 1'b1, 30'h400});
      tick();
      apply(mi(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h4444));
      #1;
      chk("stall_rsp", d_rdata, 32'h4444);
      tick();

      // Timeout: grant at cycle 0, no response.
      apply(mi(1, 0, 0, 1, 0, 4'hF, 32'h500, 0, 1, 0, 0));
      #1;
      chk("tmo_gnt", {31'h0, d_gnt}, 32'h1);
      tick();
      apply(mi(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      for (int c = 1; c < 8; c++) begin
         #1;
         chk($sformatf("tmo_quiet_%0d", c), {30'h0, d_rvalid, bus_err}, 32'h0);
         tick();
      end
      #1;
      check_all("tmo_fire", mo(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0));
      tick();
      #1;
      check_all("tmo_sticky", mo(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
      tick();
      tick();
      tick();
      mem_rvalid = 1'b1;
      mem_rdata  = 32'h1234;
      #1;
      check_all("late_rvalid_dropped", mo(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
      tick();

      // Reset while a fetch is outstanding.
      apply(mi(1, 1, 32'h600, 0, 0, 0, 0, 0, 1, 0, 0));
      #1;
      chk("rst_fetch_gnt", {31'h0, if_gnt}, 32'h1);
      tick();
      apply(mi(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      tick();
      apply(mi(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h77));
      #1;
      check_all("rst_mid_wait", '0);
      tick();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

- Shares the single unified memory port of the RV32I core between two requesters: instruction fetch (I) and load/store data (D).
- Tracks one outstanding transaction at a time and routes each response back to the requester that issued it.
- D has priority over I; a streak limit prevents fetch starvation, and a response timeout prevents a hung memory from deadlocking the core.

## Interface
Parameters:
- STREAK_MAX, 4: consecutive D grants allowed while I is waiting.
- TIMEOUT_CYCLES, 64: maximum cycles from grant to mem_rvalid.

Ports:
- clk  in  1  system clock; one clock domain, synchronous and active-low reset.
- rst_n  in  1  reset.
- if_req  in  1  fetch request.
- if_addr  in  32  fetch address.
- if_gnt  out  1  fetch accepted.
- if_rvalid  out  1  fetch response valid.
- if_rdata  out  32  fetch response data.
- if_err  out  1  fetch response carries a timeout error.
- d_req  in  1  data request.
- d_we  in  1  1 = store.
- d_be  in  4  byte enables.
- d_addr  in  32  data address.
- d_wdata  in  32  store data.
- d_gnt  out  1  data request accepted.
- d_rvalid  out  1  data response valid (load data or store acknowledge).
- d_rdata  out  32  load data.
- d_err  out  1  data response carries a timeout error.
- mem_req  out  1  memory request.
- mem_we  out  1  memory write enable.
- mem_be  out  4  memory byte enables.
- mem_addr  out  32  memory address.
- mem_wdata  out  32  memory write data.
- mem_gnt  in  1  memory accepted the request.
- mem_rvalid  in  1  memory response valid; exactly one per accepted request.
- mem_rdata  in  32  memory response data.
- bus_err  out  1  sticky flag, set by any timeout, cleared only by reset.

## Operation
- FSM states:
  - IDLE: no transaction outstanding.
  - REQ: a requester is selected and locked; mem_req is held until mem_gnt.
  - WAIT: accepted, waiting for mem_rvalid.
- Selection in IDLE when any request is high:
  - D wins if d_req is high and streak < STREAK_MAX; otherwise I wins if if_req is high.
  - The selection is locked into the owner register.
- mem_req is high in REQ, and also in IDLE combinationally whenever a request is present.
- The mem_* command fields are driven from the locked or selected owner and stay stable until mem_gnt.
- Grant: the selected requester's gnt = mem_gnt during mem_req; then go to WAIT.
- Requesters must hold req and command fields stable until gnt.
- Streak counter:
  - increments on a D grant while if_req is high;
  - clears on an I grant or any cycle with if_req low;
  - saturates at STREAK_MAX.
- In WAIT:
  - On mem_rvalid, the owner's rvalid is asserted with rdata = mem_rdata (combinational pass-through) and err = 0; go to IDLE.
  - The other requester's rvalid, rdata and err outputs stay 0.
  - The timeout counter counts cycles in WAIT. On reaching TIMEOUT_CYCLES with no mem_rvalid, the owner gets rvalid = 1, err = 1, rdata = 0 for one cycle; set bus_err; go to IDLE.
- A mem_rvalid arriving in IDLE or REQ (late, after a timeout) is dropped; no requester output toggles.
- Stores also complete via mem_rvalid; d_rdata is 0 on store responses.

## Timing
- Reset values: all outputs 0; state IDLE, streak 0, timeout counter 0, bus_err 0, owner = D.
- Fastest transaction:
  - cycle 0: req and mem_gnt high, gnt high;
  - cycle 1 or later: mem_rvalid; the requester sees rvalid in the same cycle.
- No new grant in the cycle a response completes; the next grant is earliest one cycle after rvalid.
- Throughput is therefore at most one transaction per 2 cycles.
- Simultaneous if_req and d_req: resolved by the selection rule above; the losing request waits, with no gnt.
- The timeout counter resets on every grant and has width $clog2(TIMEOUT_CYCLES+1).
- Reset asserted mid-transaction: return to IDLE next edge; the outstanding transaction is abandoned.
- A mem_rvalid in the first cycle after reset release is dropped.

## Structure
- Package mem_arb_pkg holds:
  - state enum {IDLE, REQ, WAIT};
  - owner enum {OWN_I, OWN_D};
  - default parameter constants.
- Sub-module arb_pick: combinational priority plus the streak register (inputs if_req, d_req, grant events; output the selected owner).
- The top level holds the FSM, owner register, timeout counter and routing muxes.

## Test plan
- Single fetch, memory latency 1: if_req, addr 0x100; mem_gnt at cycle 0 -> if_gnt at cycle 0; mem_rdata 0x00000013 at cycle 1 -> if_rvalid with 0x13, d_rvalid 0.
- Both request continuously, STREAK_MAX=4, mem_gnt always 1 -> grant order D,D,D,D,I,D,D,D,D,I.
- mem_gnt held low 5 cycles -> mem_req high, mem_addr stable every cycle, no gnt until cycle 5.
- Store: d_we=1, be=0x3, wdata 0xDEADBEEF -> mem_* match; d_rvalid on ack with d_rdata 0, d_err 0.
- Timeout: TIMEOUT_CYCLES=8, no mem_rvalid -> d_rvalid and d_err high 8 cycles after grant, bus_err sticky; a late mem_rvalid at cycle 12 is ignored.
- Reset pulled low while in WAIT -> all outputs 0 next cycle; a following mem_rvalid produces no rvalid.
